crc_tx_generator: RTL and testbench
===================================

// Module: crc_tx_generator
// PURPOSE
//  Transmit-side CAN CRC-15 unit. Accumulates the CRC serially over the destuffed frame
//  bits (SOF through end of data field) as the TX bit engine emits them, then serialises
//  the 15 CRC bits MSB-first into the CRC field on request. Sits between the TX frame
//  sequencer and the bit stuffer; the receive-side CRC checker closes the loop.
// PARAMETERS
//  CRC_WIDTH  15        CRC length in bits
//  CRC_POLY   15'h4599  generator x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, without x^15 term
//  CRC_INIT   15'h0000  register value loaded on start
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  enable          in   1   block enable; low acts as synchronous clear
//  start           in   1   frame start: load CRC_INIT, enter ACCUM
//  data_bit        in   1   destuffed frame bit
//  data_valid      in   1   qualifies data_bit, one pulse per bit time
//  crc_send        in   1   end of data field: latch CRC, begin serialising
//  bit_ready       in   1   bit-time strobe from TX engine, advances the CRC field
//  crc_bit         out  1   current CRC field bit, MSB first
//  crc_bit_valid   out  1   high while crc_bit carries a CRC field bit
//  crc_value       out  15  accumulated/final CRC, held until next start
//  busy            out  1   high in ACCUM or SHIFT
//  crc_done        out  1   one-cycle pulse after the last CRC bit is consumed
//  protocol_error  out  1   one-cycle pulse on an illegal request
// BEHAVIOUR
//  Reset, or enable low: state=IDLE; crc_value=0; shift reg=0; count=0; every output 0.
//  Step function: fb = bit ^ crc[14]; crc' = {crc[13:0],1'b0} ^ (fb ? CRC_POLY : 0).
//  FSM IDLE -> ACCUM -> SHIFT -> IDLE:
//   IDLE : data_valid, bit_ready ignored. start -> ACCUM, crc=CRC_INIT.
//          crc_send -> protocol_error pulse, stay IDLE.
//   ACCUM: data_valid -> crc=step(crc,data_bit), registered, visible on crc_value next cycle.
//          crc_send -> SHIFT; shift reg=final CRC; count=14.
//   SHIFT: crc_bit = shift_reg[14] (registered, no comb path); crc_bit_valid=1.
//          bit_ready: shift left 1, count-1. bit_ready at count==0 -> IDLE, crc_done
//          pulses next cycle, crc_bit_valid low same cycle. data_valid or crc_send here
//          -> protocol_error pulse, ignored.
//  Simultaneous events:
//   start wins over everything in any state (abort/restart). start+data_valid: crc=
//     step(CRC_INIT,data_bit), i.e. the SOF bit may arrive with start.
//   data_valid+crc_send in ACCUM: bit is folded in first; latched CRC includes it.
//   bit_ready in the cycle SHIFT is entered is ignored; first shift needs a later strobe.
//  crc_value: in ACCUM tracks running CRC; frozen from crc_send until next start/reset.
//  Latency: data_valid -> crc_value 1 cycle; crc_send -> first crc_bit_valid 1 cycle;
//   15 bit_ready strobes in SHIFT complete the field.
//  Reset or enable low mid-operation: immediate return to IDLE; no crc_done.
//  Widths: all CRC arithmetic CRC_WIDTH bits; count 4 bits, saturates at 0.
// STRUCTURE
//  Package can_crc_pkg: CRC_WIDTH, CRC_POLY, CRC_INIT constants; crc_state_e enum
//   {IDLE,ACCUM,SHIFT}; function crc15_step(crc,bit). Shared with the RX checker path.
//  One natural sub-module: crc15_lfsr (register + step, load/clear/advance inputs);
//   FSM, serialiser and counter stay in the top module.
// TESTING
//  start+data_valid(bit=1), then crc_send -> crc_value=15'h4599; crc_bit sequence on
//   15 bit_ready strobes = 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1; crc_done pulses once.
//  start, bits 1,0, crc_send -> crc_value=15'h4EAB; serialised MSB-first identically.
//  start, 20 zero bits, crc_send -> crc_value=0; 15 zero bits, crc_bit_valid high 15 strobes.
//  crc_send in IDLE; data_valid during SHIFT -> protocol_error 1-cycle pulse; CRC/field unchanged.
//  start mid-SHIFT after 5 bits -> ACCUM, crc=CRC_INIT, crc_bit_valid low, no crc_done.
//  reset (or enable low) mid-ACCUM -> all outputs 0 next cycle; following frame computes 15'h4599 again.

Source files
------------

// File: rtl/can_crc_pkg.sv
// CAN CRC-15 constants, state encoding and single-bit step function.
// Shared by the transmit generator and the receive checker.
package can_crc_pkg;

  localparam int unsigned CRC_WIDTH   = 15;
  localparam int unsigned COUNT_WIDTH = 4;

  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 15'h4599;
  localparam logic [CRC_WIDTH-1:0] CRC_INIT = 15'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2
  } crc_state_e;

  // Fold one destuffed bit into the running CRC.
  function automatic logic [CRC_WIDTH-1:0] crc15_step(input logic [CRC_WIDTH-1:0] crc,
                                                      input logic              data_bit);
    logic fb;
    fb = data_bit ^ crc[CRC_WIDTH-1];
    return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_WIDTH'(0));
  endfunction

endpackage

// File: rtl/crc15_lfsr.sv
// CRC-15 accumulation register: clear beats load, and load may fold in
// the first bit in the same cycle.
module crc15_lfsr
  import can_crc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 data_bit,
  output logic [CRC_WIDTH-1:0] crc
);

  logic [CRC_WIDTH-1:0] base_c;

  assign base_c = load ? CRC_INIT : crc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (advance) begin
      crc <= crc15_step(base_c, data_bit);
    end else if (load) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/crc_tx_generator.sv
// Transmit-side CAN CRC-15: accumulates frame bits, then serialises the
// 15-bit CRC field MSB-first on bit-time strobes.
module crc_tx_generator
  import can_crc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 data_bit,
  input  logic                 data_valid,
  input  logic                 crc_send,
  input  logic                 bit_ready,
  output logic                 crc_bit,
  output logic                 crc_bit_valid,
  output logic [CRC_WIDTH-1:0] crc_value,
  output logic                 busy,
  output logic                 crc_done,
  output logic                 protocol_error
);

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CRC_WIDTH - 1);

  crc_state_e             state_q, state_d;
  logic [CRC_WIDTH-1:0]   shift_q, shift_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_d;
  logic                   perr_d;
  logic                   lfsr_load_c;
  logic                   lfsr_adv_c;
  logic                   clear_c;

  assign clear_c = !enable;

  crc15_lfsr u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_c),
    .load     (lfsr_load_c),
    .advance  (lfsr_adv_c),
    .data_bit (data_bit),
    .crc      (crc_value)
  );

  // Shift register MSB is itself a flop, so crc_bit has no combinational path.
  assign crc_bit = shift_q[CRC_WIDTH-1];

  // Next-state, serialiser and LFSR control; start overrides every state.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    done_d      = 1'b0;
    perr_d      = 1'b0;
    lfsr_load_c = 1'b0;
    lfsr_adv_c  = 1'b0;
    if (start) begin
      state_d     = ACCUM;
      shift_d     = '0;
      count_d     = '0;
      lfsr_load_c = 1'b1;
      lfsr_adv_c  = data_valid;
    end else begin
      case (state_q)
        IDLE: begin
          if (crc_send) perr_d = 1'b1;
        end
        ACCUM: begin
          lfsr_adv_c = data_valid;
          if (crc_send) begin
            state_d = SHIFT;
            shift_d = data_valid ? crc15_step(crc_value, data_bit) : crc_value;
            count_d = LAST_COUNT;
          end
        end
        SHIFT: begin
          if (data_valid || crc_send) perr_d = 1'b1;
          if (bit_ready) begin
            shift_d = {shift_q[CRC_WIDTH-2:0], 1'b0};
            if (count_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              count_d = COUNT_WIDTH'(count_q - 1'b1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_c) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      count_q        <= '0;
      busy           <= 1'b0;
      crc_bit_valid  <= 1'b0;
      crc_done       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      count_q        <= count_d;
      busy           <= (state_d != IDLE);
      crc_bit_valid  <= (state_d == SHIFT);
      crc_done       <= done_d;
      protocol_error <= perr_d;
    end
  end

endmodule

// File: tb/tb_crc_tx_generator.sv
// Directed bench for crc_tx_generator with hand-computed CRC-15 vectors.
module tb_crc_tx_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        data_bit = 1'b0;
  logic        data_valid = 1'b0;
  logic        crc_send = 1'b0;
  logic        bit_ready = 1'b0;
  logic        crc_bit;
  logic        crc_bit_valid;
  logic [14:0] crc_value;
  logic        busy;
  logic        crc_done;
  logic        protocol_error;

  int checks = 0;
  int failures = 0;

  crc_tx_generator dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .data_bit       (data_bit),
    .data_valid     (data_valid),
    .crc_send       (crc_send),
    .bit_ready      (bit_ready),
    .crc_bit        (crc_bit),
    .crc_bit_valid  (crc_bit_valid),
    .crc_value      (crc_value),
    .busy           (busy),
    .crc_done       (crc_done),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  // Advance one clock, sample point is 1ns after the edge; pulse inputs drop.
  task automatic tick();
    @(posedge clock);
    #1;
    start      = 1'b0;
    data_valid = 1'b0;
    crc_send   = 1'b0;
    bit_ready  = 1'b0;
  endtask

  // Shift out CRC field bits first..14 and check the trailing crc_done pulse.
  task automatic shift_and_check(input logic [14:0] exp_crc, input int first, input string tag);
    logic [14:0] exp_v;
    exp_v = exp_crc;
    for (int i = first; i < 15; i++) begin
      checks++;
      if (crc_bit !== exp_v[14-i] || crc_bit_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s bit%0d: got bit=%b valid=%b, want bit=%b valid=1",
                 tag, i, crc_bit, crc_bit_valid, exp_v[14-i]);
      end
      bit_ready = 1'b1;
      tick();
    end
    checks++;
    if (crc_done !== 1'b1 || crc_bit_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end: got done=%b valid=%b busy=%b, want 1 0 0",
               tag, crc_done, crc_bit_valid, busy);
    end
    tick();
    checks++;
    if (crc_done !== 1'b0 || crc_value !== exp_crc) begin
      failures++;
      $display("FAIL %s after: got done=%b crc=%h, want done=0 crc=%h",
               tag, crc_done, crc_value, exp_crc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({crc_bit, crc_bit_valid, crc_value, busy, crc_done, protocol_error} !== 20'h0) begin
      failures++;
      $display("FAIL reset: got bit=%b valid=%b crc=%h busy=%b done=%b perr=%b, want all 0",
               crc_bit, crc_bit_valid, crc_value, busy, crc_done, protocol_error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_bit();
    start = 1'b1; data_valid = 1'b1; data_bit = 1'b1;
    tick();
    checks++;
    if (crc_value !== 15'h4599 || busy !== 1'b1 || crc_bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_accum: got crc=%h busy=%b valid=%b, want 4599 1 0",
               crc_value, busy, crc_bit_valid);
    end
    crc_send = 1'b1;
    tick();
    checks++;
    if (crc_value !== 15'h4599 || crc_bit_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_send: got crc=%h valid=%b, want 4599 1", crc_value, crc_bit_valid);
    end
    shift_and_check(15'h4599, 0, "single");
  endtask

  // Second bit arrives with crc_send; a bit_ready in that cycle must be ignored.
  task automatic test_two_bits();
    start = 1'b1;
    tick();
    data_valid = 1'b1; data_bit = 1'b1;
    tick();
    data_valid = 1'b1; data_bit = 1'b0; crc_send = 1'b1; bit_ready = 1'b1;
    tick();
    checks++;
    if (crc_value !== 15'h4EAB) begin
      failures++;
      $display("FAIL two_bits_crc: got %h, want 4eab", crc_value);
    end
    shift_and_check(15'h4EAB, 0, "two_bits");
  endtask

  task automatic test_zeros();
    start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1; data_bit = 1'b0;
      tick();
    end
    crc_send = 1'b1;
    tick();
    checks++;
    if (crc_value !== 15'h0000) begin
      failures++;
      $display("FAIL zeros_crc: got %h, want 0000", crc_value);
    end
    shift_and_check(15'h0000, 0, "zeros");
  endtask

  task automatic test_protocol_error();
    crc_send = 1'b1;
    tick();
    checks++;
    if (protocol_error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL perr_idle: got perr=%b busy=%b, want 1 0", protocol_error, busy);
    end
    tick();
    checks++;
    if (protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL perr_idle_pulse: got perr=%b, want 0", protocol_error);
    end
    start = 1'b1; data_valid = 1'b1; data_bit = 1'b1;
    tick();
    crc_send = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bit_ready = 1'b1;
      tick();
    end
    data_valid = 1'b1; data_bit = 1'b1;
    tick();
    checks++;
    if (protocol_error !== 1'b1 || crc_value !== 15'h4599 || crc_bit !== 1'b0 ||
        crc_bit_valid !== 1'b1) begin
      failures++;
      $display("FAIL perr_shift: got perr=%b crc=%h bit=%b valid=%b, want 1 4599 0 1",
               protocol_error, crc_value, crc_bit, crc_bit_valid);
    end
    tick();
    checks++;
    if (protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL perr_shift_pulse: got perr=%b, want 0", protocol_error);
    end
    shift_and_check(15'h4599, 3, "perr_resume");
  endtask

  task automatic test_restart();
    start = 1'b1; data_valid = 1'b1; data_bit = 1'b1;
    tick();
    crc_send = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bit_ready = 1'b1;
      tick();
    end
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || crc_bit_valid !== 1'b0 || crc_value !== 15'h0000 ||
        crc_done !== 1'b0 || crc_bit !== 1'b0) begin
      failures++;
      $display("FAIL restart: got busy=%b valid=%b crc=%h done=%b bit=%b, want 1 0 0000 0 0",
               busy, crc_bit_valid, crc_value, crc_done, crc_bit);
    end
    tick();
    checks++;
    if (crc_done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_hold: got done=%b busy=%b, want 0 1", crc_done, busy);
    end
  endtask

  task automatic test_abort(input logic use_enable);
    start = 1'b1; data_valid = 1'b1; data_bit = 1'b1;
    tick();
    if (use_enable) enable = 1'b0;
    else reset = 1'b1;
    tick();
    checks++;
    if ({crc_bit, crc_bit_valid, crc_value, busy, crc_done, protocol_error} !== 20'h0) begin
      failures++;
      $display("FAIL abort(en=%0b): got valid=%b crc=%h busy=%b done=%b, want all 0",
               use_enable, crc_bit_valid, crc_value, busy, crc_done);
    end
    enable = 1'b1;
    reset  = 1'b0;
    tick();
    start = 1'b1; data_valid = 1'b1; data_bit = 1'b1;
    tick();
    crc_send = 1'b1;
    tick();
    checks++;
    if (crc_value !== 15'h4599) begin
      failures++;
      $display("FAIL abort_refresh(en=%0b): got %h, want 4599", use_enable, crc_value);
    end
    shift_and_check(15'h4599, 0, "abort_frame");
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_two_bits();
    test_zeros();
    test_protocol_error();
    test_restart();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
